// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes on both sides.
// Single-cycle ops finish one edge after accept.
// MUL is an iterative shift-add multiplier that takes WIDTH cycles.
module alu_seq #(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             carry_in,
    input  logic [2:0]       operator,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_zero,
    output logic             flag_carry
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    state_e             r_state;
    state_e             w_state_next;
    op_e                w_op;
    logic               w_accept;
    logic               w_is_mul;
    logic               w_last_iter;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_res;
    logic               w_cy;
    logic [WIDTH:0]     w_mul_add;
    logic [2*WIDTH-1:0] w_prod_next;

    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_result_hi;
    logic               r_zero;
    logic               r_carry;

    assign w_op        = op_e'(operator);
    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign w_accept    = in_valid && in_ready;
    assign w_is_mul    = (MUL_EN != 0) && (w_op == OP_MUL);
    assign w_last_iter = (r_cnt == CW'(WIDTH - 1));

    // Both arithmetic ops are evaluated one bit wider so bit WIDTH is the carry/borrow.
    assign w_sum  = {1'b0, operand_a} + {1'b0, operand_b} + {{WIDTH{1'b0}}, carry_in};
    assign w_diff = {1'b0, operand_a} - {1'b0, operand_b} - {{WIDTH{1'b0}}, carry_in};

    // One shift-add step: add the multiplicand to the upper half when the
    // current multiplier bit (LSB of the product register) is set, then shift right.
    assign w_mul_add   = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                       + (r_prod[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_prod_next = {w_mul_add, r_prod[WIDTH-1:1]};

    // Single-cycle result and carry from the live operand inputs (sampled on accept).
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        w_res = '0;
        w_cy  = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_cy  = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_cy  = w_diff[WIDTH];
            end
            OP_AND: w_res = operand_a & operand_b;
            OP_OR:  w_res = operand_a | operand_b;
            OP_XOR: w_res = operand_a ^ operand_b;
            OP_SHL: begin
                w_res = {operand_a[WIDTH-2:0], carry_in};
                w_cy  = operand_a[WIDTH-1];
            end
            OP_SHR: begin
                w_res = {carry_in, operand_a[WIDTH-1:1]};
                w_cy  = operand_a[0];
            end
            default: begin
                // MUL without the multiplier: zero result, zero carry.
                w_res = '0;
                w_cy  = 1'b0;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept in IDLE, iterate in MUL, hold DONE until consumed.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_next = w_is_mul ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                if (w_last_iter) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: capture operands, run multiplier iterations, load the output bundle.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every datapath register is reset so an aborted MUL leaves nothing behind.
        if (!rst_n) begin
            r_mcand     <= '0;
            r_prod      <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
        end else if (w_accept) begin
            if (w_is_mul) begin
                r_mcand <= operand_a;
                r_prod  <= {{WIDTH{1'b0}}, operand_b};
                r_cnt   <= '0;
            end else begin
                r_result    <= w_res;
                r_result_hi <= '0;
                r_zero      <= (w_res == '0);
                r_carry     <= w_cy;
            end
        end else if (r_state == S_MUL) begin
            r_prod <= w_prod_next;
            r_cnt  <= r_cnt + CW'(1);
            if (w_last_iter) begin
                r_result    <= w_prod_next[WIDTH-1:0];
                r_result_hi <= w_prod_next[2*WIDTH-1:WIDTH];
                r_zero      <= (w_prod_next == '0);
                r_carry     <= (w_prod_next[2*WIDTH-1:WIDTH] != '0);
            end
        end
    end

    assign result     = r_result;
    assign result_hi  = r_result_hi;
    assign flag_zero  = r_zero;
    assign flag_carry = r_carry;

endmodule
